// File: rtl/ysyx_22040750_pkg.sv
// Shared widths and write-back source indices for the ysyx_22040750 core.
package ysyx_22040750_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

endpackage

// File: rtl/ysyx_22040750_wbu_arb_if.sv
// Write-back arbiter bus: two result sources in, GPR write port and retire count out.
// Forwarding taps exist only when YSYX_22040750_WBU_FWD_EN is defined.
interface ysyx_22040750_wbu_arb_if
    import ysyx_22040750_pkg::*;
#(
    parameter int DW = XLEN,
    parameter int AW = REG_AW
);
    logic          I_src0_valid;
    logic          O_src0_ready;
    logic [AW-1:0] I_src0_rd;
    logic [DW-1:0] I_src0_data;

    logic          I_src1_valid;
    logic          O_src1_ready;
    logic [AW-1:0] I_src1_rd;
    logic [DW-1:0] I_src1_data;

    logic          O_wen;
    logic [AW-1:0] O_rd_addr;
    logic [DW-1:0] O_wr_data;
    logic [31:0]   O_retire_cnt;

`ifdef YSYX_22040750_WBU_FWD_EN
    logic [AW-1:0] I_rs1_addr;
    logic [AW-1:0] I_rs2_addr;
    logic          O_rs1_fwd_hit;
    logic          O_rs2_fwd_hit;
    logic [DW-1:0] O_rs1_fwd_data;
    logic [DW-1:0] O_rs2_fwd_data;
`endif

    modport slave (
        input  I_src0_valid, I_src0_rd, I_src0_data,
        input  I_src1_valid, I_src1_rd, I_src1_data,
        output O_src0_ready, O_src1_ready,
        output O_wen, O_rd_addr, O_wr_data, O_retire_cnt
`ifdef YSYX_22040750_WBU_FWD_EN
        ,
        input  I_rs1_addr, I_rs2_addr,
        output O_rs1_fwd_hit, O_rs2_fwd_hit, O_rs1_fwd_data, O_rs2_fwd_data
`endif
    );

    modport master (
        output I_src0_valid, I_src0_rd, I_src0_data,
        output I_src1_valid, I_src1_rd, I_src1_data,
        input  O_src0_ready, O_src1_ready,
        input  O_wen, O_rd_addr, O_wr_data, O_retire_cnt
`ifdef YSYX_22040750_WBU_FWD_EN
        ,
        output I_rs1_addr, I_rs2_addr,
        input  O_rs1_fwd_hit, O_rs2_fwd_hit, O_rs1_fwd_data, O_rs2_fwd_data
`endif
    );

endinterface

// File: rtl/ysyx_22040750_rr_arb2.sv
// Two-requester round-robin arbiter; grants are combinational, last-grant is a single flop.
module ysyx_22040750_rr_arb2
    import ysyx_22040750_pkg::*;
(
    input  logic I_sys_clk,
    input  logic I_rst,
    input  logic I_req0,
    input  logic I_req1,
    output logic O_gnt0,
    output logic O_gnt1
);

    src_e last_grant;

    always_comb begin
        O_gnt0 = 1'b0;
        O_gnt1 = 1'b0;
        if (!I_rst) begin
            if (I_req0 && I_req1) begin
                if (last_grant == SRC_ALU) O_gnt1 = 1'b1;
                else                       O_gnt0 = 1'b1;
            end else begin
                O_gnt0 = I_req0;
                O_gnt1 = I_req1;
            end
        end
    end

    // Reset to LSU so the ALU wins the first contested cycle.
    always_ff @(posedge I_sys_clk) begin
        if (I_rst)       last_grant <= SRC_LSU;
        else if (O_gnt0) last_grant <= SRC_ALU;
        else if (O_gnt1) last_grant <= SRC_LSU;
    end

endmodule

// File: rtl/ysyx_22040750_wbu_arb.sv
// Write-back unit arbiter: picks one of ALU/LSU results per cycle and registers it onto the GPR write port.
// Optional forwarding taps enabled by YSYX_22040750_WBU_FWD_EN.
module ysyx_22040750_wbu_arb
    import ysyx_22040750_pkg::*;
#(
    parameter int DW = XLEN,
    parameter int AW = REG_AW
) (
    input  logic                     I_sys_clk,
    input  logic                     I_rst,
    ysyx_22040750_wbu_arb_if.slave   bus
);

    logic          gnt0;
    logic          gnt1;
    logic          any_gnt;
    logic [AW-1:0] sel_rd;
    logic [DW-1:0] sel_data;

    logic          wen_q;
    logic [AW-1:0] rd_q;
    logic [DW-1:0] data_q;
    logic [31:0]   retire_cnt;

    ysyx_22040750_rr_arb2 u_rr_arb2 (
        .I_sys_clk (I_sys_clk),
        .I_rst     (I_rst),
        .I_req0    (bus.I_src0_valid),
        .I_req1    (bus.I_src1_valid),
        .O_gnt0    (gnt0),
        .O_gnt1    (gnt1)
    );

    assign any_gnt  = gnt0 | gnt1;
    assign sel_rd   = gnt1 ? bus.I_src1_rd   : bus.I_src0_rd;
    assign sel_data = gnt1 ? bus.I_src1_data : bus.I_src0_data;

    assign bus.O_src0_ready = gnt0;
    assign bus.O_src1_ready = gnt1;

    // x0 writes still retire and load the address/data, but never strobe the GPR file.
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            wen_q      <= 1'b0;
            rd_q       <= '0;
            data_q     <= '0;
            retire_cnt <= '0;
        end else begin
            wen_q <= any_gnt && (sel_rd != '0);
            if (any_gnt) begin
                rd_q       <= sel_rd;
                data_q     <= sel_data;
                retire_cnt <= retire_cnt + 32'd1;
            end
        end
    end

    assign bus.O_wen        = wen_q;
    assign bus.O_rd_addr    = rd_q;
    assign bus.O_wr_data    = data_q;
    assign bus.O_retire_cnt = retire_cnt;

`ifdef YSYX_22040750_WBU_FWD_EN
    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = wen_q && (bus.I_rs1_addr != '0) && (bus.I_rs1_addr == rd_q);
    assign rs2_hit = wen_q && (bus.I_rs2_addr != '0) && (bus.I_rs2_addr == rd_q);

    assign bus.O_rs1_fwd_hit  = rs1_hit;
    assign bus.O_rs2_fwd_hit  = rs2_hit;
    assign bus.O_rs1_fwd_data = rs1_hit ? data_q : '0;
    assign bus.O_rs2_fwd_data = rs2_hit ? data_q : '0;
`endif

endmodule

// File: tb/tb_ysyx_22040750_wbu_arb.sv
// Directed self-checking bench for ysyx_22040750_wbu_arb (vector table plus corner sequences).
module tb_ysyx_22040750_wbu_arb;

    logic I_sys_clk = 1'b0;
    logic I_rst     = 1'b1;

    always #5 I_sys_clk = ~I_sys_clk;

    ysyx_22040750_wbu_arb_if #(.DW(64), .AW(5)) bus ();

    ysyx_22040750_wbu_arb #(.DW(64), .AW(5)) dut (
        .I_sys_clk (I_sys_clk),
        .I_rst     (I_rst),
        .bus       (bus)
    );

    typedef struct {
        logic        v0;
        logic [4:0]  rd0;
        logic [63:0] d0;
        logic        v1;
        logic [4:0]  rd1;
        logic [63:0] d1;
        logic        r0;
        logic        r1;
        logic        wen;
        logic [4:0]  rd;
        logic [63:0] data;
        logic [31:0] cnt;
    } vec_t;

    vec_t vec [9];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge I_sys_clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [4:0] rd0, input logic [63:0] d0,
                         input logic v1, input logic [4:0] rd1, input logic [63:0] d1);
        bus.I_src0_valid = v0;
        bus.I_src0_rd    = rd0;
        bus.I_src0_data  = d0;
        bus.I_src1_valid = v1;
        bus.I_src1_rd    = rd1;
        bus.I_src1_data  = d1;
    endtask

    task automatic check_out(input string tag, input logic wen, input logic [4:0] rd,
                             input logic [63:0] data, input logic [31:0] cnt);
        check({tag, " wen"},  64'(bus.O_wen),        64'(wen));
        check({tag, " rd"},   64'(bus.O_rd_addr),    64'(rd));
        check({tag, " data"}, bus.O_wr_data,         data);
        check({tag, " cnt"},  64'(bus.O_retire_cnt), 64'(cnt));
    endtask

    task automatic check_rdy(input string tag, input logic r0, input logic r1);
        check({tag, " ready0"}, 64'(bus.O_src0_ready), 64'(r0));
        check({tag, " ready1"}, 64'(bus.O_src1_ready), 64'(r1));
    endtask

    initial begin
        // Expected values assume last-grant starts at LSU and moves only on grants.
        vec[0] = '{1'b1, 5'd5,  64'h1234, 1'b0, 5'd0,  64'h0,    1'b1, 1'b0, 1'b1, 5'd5,  64'h1234, 32'd1};
        vec[1] = '{1'b1, 5'd1,  64'h11,   1'b1, 5'd2,  64'h22,   1'b0, 1'b1, 1'b1, 5'd2,  64'h22,   32'd2};
        vec[2] = '{1'b1, 5'd3,  64'h33,   1'b1, 5'd4,  64'h44,   1'b1, 1'b0, 1'b1, 5'd3,  64'h33,   32'd3};
        vec[3] = '{1'b0, 5'd8,  64'h88,   1'b0, 5'd9,  64'h99,   1'b0, 1'b0, 1'b0, 5'd3,  64'h33,   32'd3};
        vec[4] = '{1'b1, 5'd6,  64'h66,   1'b1, 5'd7,  64'h77,   1'b0, 1'b1, 1'b1, 5'd7,  64'h77,   32'd4};
        vec[5] = '{1'b0, 5'd0,  64'h0,    1'b1, 5'd0,  64'hDEAD, 1'b0, 1'b1, 1'b0, 5'd0,  64'hDEAD, 32'd5};
        vec[6] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd0, 64'h0,
                   1'b1, 1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 32'd6};
        vec[7] = '{1'b0, 5'd0,  64'h0,    1'b1, 5'd9,  64'h99,   1'b0, 1'b1, 1'b1, 5'd9,  64'h99,   32'd7};
        vec[8] = '{1'b1, 5'd10, 64'hA0,   1'b1, 5'd11, 64'hB0,   1'b1, 1'b0, 1'b1, 5'd10, 64'hA0,   32'd8};

`ifdef YSYX_22040750_WBU_FWD_EN
        bus.I_rs1_addr = '0;
        bus.I_rs2_addr = '0;
`endif
        // Valids high during reset: readys must still stay low.
        drive(1'b1, 5'd1, 64'h1, 1'b1, 5'd2, 64'h2);
        tick();
        tick();
        check_rdy("reset", 1'b0, 1'b0);
        check_out("reset", 1'b0, 5'd0, 64'h0, 32'd0);

        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        I_rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            drive(vec[i].v0, vec[i].rd0, vec[i].d0, vec[i].v1, vec[i].rd1, vec[i].d1);
            #1;
            check_rdy($sformatf("vec%0d", i), vec[i].r0, vec[i].r1);
            tick();
            check_out($sformatf("vec%0d", i), vec[i].wen, vec[i].rd, vec[i].data, vec[i].cnt);
        end

        // Back-to-back contention right after reset: grants alternate 0,1,0,1.
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        I_rst = 1'b1;
        tick();
        I_rst = 1'b0;
        drive(1'b1, 5'd8, 64'h800, 1'b1, 5'd16, 64'h1600);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_rdy($sformatf("rr%0d", i), (i % 2) == 0, (i % 2) == 1);
            tick();
            if ((i % 2) == 0) check_out($sformatf("rr%0d", i), 1'b1, 5'd8,  64'h800,  32'(i + 1));
            else              check_out($sformatf("rr%0d", i), 1'b1, 5'd16, 64'h1600, 32'(i + 1));
        end

        // Counter wrap: preload all-ones during an idle cycle, then one handshake.
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt;
        #1;
        check("wrap preload", 64'(bus.O_retire_cnt), 64'hFFFF_FFFF);
        tick();
        drive(1'b1, 5'd12, 64'hC, 1'b0, 5'd0, 64'h0);
        tick();
        check_out("wrap", 1'b1, 5'd12, 64'hC, 32'd0);

        // Reset in the cycle after a grant discards the registered write.
        drive(1'b1, 5'd5, 64'h55, 1'b0, 5'd0, 64'h0);
        #1;
        check_rdy("prerst", 1'b1, 1'b0);
        tick();
        I_rst = 1'b1;
        drive(1'b1, 5'd3, 64'h3, 1'b1, 5'd4, 64'h4);
        #1;
        check_rdy("midrst", 1'b0, 1'b0);
        tick();
        check_out("midrst", 1'b0, 5'd0, 64'h0, 32'd0);
        I_rst = 1'b0;
        #1;
        check_rdy("postrst", 1'b1, 1'b0);
        tick();
        check_out("postrst", 1'b1, 5'd3, 64'h3, 32'd1);

`ifdef YSYX_22040750_WBU_FWD_EN
        drive(1'b1, 5'd7, 64'h55, 1'b0, 5'd0, 64'h0);
        tick();
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        bus.I_rs1_addr = 5'd7;
        bus.I_rs2_addr = 5'd0;
        #1;
        check("fwd rs1 hit",  64'(bus.O_rs1_fwd_hit), 64'd1);
        check("fwd rs1 data", bus.O_rs1_fwd_data,     64'h55);
        check("fwd rs2 hit",  64'(bus.O_rs2_fwd_hit), 64'd0);
        check("fwd rs2 data", bus.O_rs2_fwd_data,     64'h0);
        bus.I_rs2_addr = 5'd6;
        #1;
        check("fwd rs2 miss", 64'(bus.O_rs2_fwd_hit), 64'd0);
`endif

        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22040750_wbu_arb.md
YSYX_22040750_WBU_ARB -- requirements
Module: ysyx_22040750_wbu_arb

Interface
REQ-001 SHALL have parameter DW, default 64: write-back data width.
REQ-002 SHALL have parameter AW, default 5: register address width.
REQ-003 SHALL have port I_sys_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port I_rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have ports I_src0_valid, input, 1, and O_src0_ready, output, 1: ALU/CSR result handshake.
REQ-006 SHALL have ports I_src0_rd, input, AW, and I_src0_data, input, DW: ALU/CSR destination and value.
REQ-007 SHALL have ports I_src1_valid, input, 1, and O_src1_ready, output, 1: load-unit result handshake.
REQ-008 SHALL have ports I_src1_rd, input, AW, and I_src1_data, input, DW: load destination and value.
REQ-009 SHALL have ports O_wen, output, 1; O_rd_addr, output, AW; O_wr_data, output, DW: drive the GPR file write port.
REQ-010 SHALL have port O_retire_cnt, output, 32: count of completed write-back handshakes.

Function
REQ-011 SHALL complete a handshake on source N in a cycle where valid and ready are both high.
REQ-012 SHALL assert at most one ready per cycle; ready is combinational from valids and arbitration state, with no dependence on ready inputs (none exist).
REQ-013 SHALL grant the sole valid source when only one is valid.
REQ-014 SHALL, when both are valid, grant the source not granted in the most recent grant cycle (round-robin, 1-bit last-grant flop).
REQ-015 SHALL update the last-grant flop only in cycles where a grant occurs.
REQ-016 SHALL register the granted rd/data into O_rd_addr/O_wr_data and set O_wen high in the next cycle: latency exactly 1 cycle.
REQ-017 SHALL, for a granted rd of 0, complete the handshake, load O_rd_addr/O_wr_data, and keep O_wen low.
REQ-018 SHALL, in a cycle with no grant, drive O_wen low next cycle and hold O_rd_addr/O_wr_data.
REQ-019 SHALL increment O_retire_cnt by 1 per completed handshake, including rd=0, wrapping 0xFFFFFFFF -> 0.
REQ-020 SHALL sustain one write-back per cycle indefinitely; the GPR side never back-pressures.

Reset
REQ-021 SHALL clear O_wen, O_rd_addr, O_wr_data and O_retire_cnt to 0 when I_rst is high at a clock edge.
REQ-022 SHALL set last-grant so src0 wins the first both-valid cycle after reset.
REQ-023 SHALL hold O_src0_ready and O_src1_ready low while I_rst is high; no handshake completes during reset, and reset mid-transfer discards the pending registered write.

Configuration
REQ-024 SHALL, with macro YSYX_22040750_WBU_FWD_EN defined, add inputs I_rs1_addr/I_rs2_addr (AW) and outputs O_rs1_fwd_hit/O_rs2_fwd_hit (1) and O_rs1_fwd_data/O_rs2_fwd_data (DW).
REQ-025 SHALL, with the macro defined, assert fwd_hit when O_wen is high, O_rd_addr equals the rs address and rs address is nonzero, with fwd_data equal to O_wr_data; fwd_data is 0 when fwd_hit is low.
REQ-026 SHALL, without the macro, omit those ports and logic entirely; all other behaviour identical.

Structure
REQ-027 SHALL take XLEN (64), REG_AW (5) and the source-index enum (SRC_ALU=0, SRC_LSU=1) from shared package ysyx_22040750_pkg.
REQ-028 SHALL place the two-requester round-robin arbiter, including last-grant flop, in sub-module ysyx_22040750_rr_arb2.

Verification
REQ-029 SHALL cover: src0 valid rd=5 data=0x1234 alone -> ready0 same cycle; next cycle O_wen=1, O_rd_addr=5, O_wr_data=0x1234; O_retire_cnt=1.
REQ-030 SHALL cover: both valid for 4 cycles after reset -> grants 0,1,0,1; O_rd_addr sequence follows, one write per cycle.
REQ-031 SHALL cover: src1 valid rd=0 data=0xDEAD -> ready1 high; next cycle O_wen=0, O_retire_cnt increments.
REQ-032 SHALL cover: O_retire_cnt forced via 0xFFFFFFFF handshakes (or preload by backdoor) -> next handshake yields 0.
REQ-033 SHALL cover: I_rst high in cycle after a grant -> O_wen=0, outputs 0, readys low; first both-valid after release grants src0.
REQ-034 SHALL cover (FWD_EN): O_wen=1, O_rd_addr=7, O_wr_data=0x55, I_rs1_addr=7, I_rs2_addr=0 -> rs1 hit with 0x55, rs2 no hit, data 0.
